// File: rtl/keypad_scanner.sv
// keypad_scanner: generic ROWS x COLS matrix keypad scanner with whole-matrix
// debounce, multi-key rejection and a first-word-fall-through event FIFO.
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYC     = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int KW            = $clog2(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [COLS-1:0] col_n,
    input  logic [ROWS-1:0] row_n,
    output logic [KW:0]     evt_data,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic            overflow,
    input  logic            overflow_clr,
    output logic            held,
    output logic            multi
);

    localparam int NK = ROWS * COLS;
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(SETTLE_CYC);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        EV_IDLE,
        EV_REL,
        EV_PRESS
    } ev_state_e;

    logic [ROWS-1:0] row_meta_q, row_meta_d, row_sync_q, row_sync_d;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [NK-1:0]   snap_q, snap_d, prev_q, prev_d, deb_q, deb_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic            commit_q, commit_d;
    logic            last_dwell, scan_end;

    ev_state_e       state_q, state_d;
    logic [KW-1:0]   key_q, key_d, pend_q, pend_d;
    logic            held_q, held_d, multi_q, multi_d;
    logic [1:0]      nkeys;
    logic [KW-1:0]   first_key;
    logic            push;
    logic [KW:0]     push_data;

    logic [KW:0]     mem_q [FIFO_DEPTH];
    logic [KW:0]     mem_d [FIFO_DEPTH];
    logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic            overflow_q, overflow_d;
    logic            full, empty, pop, push_ok, drop;

    // Synchroniser, column scan, snapshot capture and debounce/commit
    always_comb begin
        row_meta_d = row_n;
        row_sync_d = row_meta_q;
        last_dwell = (dwell_q == DWELL_LAST);
        scan_end   = last_dwell && (col_q == COL_LAST);
        dwell_d    = last_dwell ? '0 : dwell_q + 1'b1;
        col_d      = col_q;
        if (last_dwell) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        end
        snap_d = snap_q;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (last_dwell && (col_q == CW'(c))) begin
                    snap_d[r*COLS + c] = ~row_sync_q[r];
                end
            end
        end
        prev_d   = prev_q;
        stable_d = stable_q;
        deb_d    = deb_q;
        commit_d = 1'b0;
        if (scan_end) begin
            if (snap_d == prev_q) begin
                stable_d = (stable_q == STABLE_MAX) ? stable_q : stable_q + 1'b1;
            end else begin
                stable_d = SW'(1);
            end
            prev_d = snap_d;
            if (stable_d == STABLE_MAX) begin
                deb_d    = snap_d;
                commit_d = 1'b1;
            end
        end
        col_n = '1;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (col_q == CW'(c)) col_n[c] = 1'b0;
        end
    end

    // Classify the debounced snapshot: none / one / several keys, lowest code
    always_comb begin
        nkeys     = 2'd0;
        first_key = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            if (deb_q[i]) begin
                if (nkeys == 2'd0) first_key = KW'(i);
                if (nkeys != 2'd2) nkeys = nkeys + 1'b1;
            end
        end
    end

    // Event FSM: turns committed snapshots into press/release pushes
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        pend_d    = pend_q;
        held_d    = held_q;
        multi_d   = multi_q;
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            EV_IDLE: begin
                if (commit_q) begin
                    if (nkeys == 2'd0) begin
                        multi_d = 1'b0;
                        if (held_q) begin
                            push      = 1'b1;
                            push_data = {1'b0, key_q};
                            held_d    = 1'b0;
                        end
                    end else if (nkeys == 2'd1) begin
                        multi_d = 1'b0;
                        if (!held_q) begin
                            push      = 1'b1;
                            push_data = {1'b1, first_key};
                            key_d     = first_key;
                            held_d    = 1'b1;
                        end else if (first_key != key_q) begin
                            pend_d  = first_key;
                            state_d = EV_REL;
                        end
                    end else begin
                        multi_d = 1'b1;
                    end
                end
            end
            EV_REL: begin
                push      = 1'b1;
                push_data = {1'b0, key_q};
                state_d   = EV_PRESS;
            end
            EV_PRESS: begin
                push      = 1'b1;
                push_data = {1'b1, pend_q};
                key_d     = pend_q;
                state_d   = EV_IDLE;
            end
            default: state_d = EV_IDLE;
        endcase
    end

    // Event FIFO: a push on full is still accepted when the head pops that cycle
    always_comb begin
        empty      = (wptr_q == rptr_q);
        full       = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop        = !empty && evt_ready;
        push_ok    = push && (!full || pop);
        drop       = push && full && !pop;
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = push_data;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
        overflow_d = drop ? 1'b1 : (overflow_clr ? 1'b0 : overflow_q);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            col_q      <= '0;
            dwell_q    <= '0;
            snap_q     <= '0;
            prev_q     <= '0;
            deb_q      <= '0;
            stable_q   <= '0;
            commit_q   <= 1'b0;
            state_q    <= EV_IDLE;
            key_q      <= '0;
            pend_q     <= '0;
            held_q     <= 1'b0;
            multi_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            col_q      <= col_d;
            dwell_q    <= dwell_d;
            snap_q     <= snap_d;
            prev_q     <= prev_d;
            deb_q      <= deb_d;
            stable_q   <= stable_d;
            commit_q   <= commit_d;
            state_q    <= state_d;
            key_q      <= key_d;
            pend_q     <= pend_d;
            held_q     <= held_d;
            multi_q    <= multi_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign evt_data  = mem_q[rptr_q[AW-1:0]];
    assign evt_valid = !empty;
    assign overflow  = overflow_q;
    assign held      = held_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, event scoreboard, scenario tasks.
module tb_keypad_scanner;

    localparam int SCAN = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [4:0] evt_data;
    logic       evt_valid;
    logic       evt_ready;
    logic       overflow;
    logic       overflow_clr;
    logic       held;
    logic       multi;

    logic [15:0] keys = '0;
    logic [4:0]  exp_q[$];
    logic [4:0]  exp_v;
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int pop_cyc     = 0;
    int prev_pop_cyc = 0;

    keypad_scanner #(
        .ROWS(4),
        .COLS(4),
        .SETTLE_CYC(8),
        .DEBOUNCE_SCANS(3),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .col_n(col_n),
        .row_n(row_n),
        .evt_data(evt_data),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .overflow(overflow),
        .overflow_clr(overflow_clr),
        .held(held),
        .multi(multi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Scoreboard: every pop is compared with the oldest expected event
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL evt_unexpected: got %b, required no event", evt_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (evt_data !== exp_v) begin
                    miscompares++;
                    $display("FAIL evt_data: got %b, required %b", evt_data, exp_v);
                end
            end
            prev_pop_cyc = pop_cyc;
            pop_cyc      = cyc;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic wait_scans(input int n);
        repeat (n * SCAN) @(negedge clk);
    endtask

    // Returns on the negedge just after a scan wraps from column 3 to column 0
    task automatic align_scan();
        int n;
        n = 0;
        while (col_n !== 4'b0111 && n < 200) begin @(negedge clk); n++; end
        while (col_n !== 4'b1110 && n < 400) begin @(negedge clk); n++; end
        vectors++;
        if (col_n !== 4'b1110) begin
            miscompares++;
            $display("FAIL align_timeout: got col_n %b, required %b", col_n, 4'b1110);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_cn;
        rst_n = 1'b0; keys = '0; evt_ready = 1'b1; overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (col_n !== 4'b1110) begin miscompares++; $display("FAIL reset_col_n: got %b, required %b", col_n, 4'b1110); end
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_evt_valid: got %b, required 0", evt_valid); end
        vectors++; if (evt_data !== 5'b0) begin miscompares++; $display("FAIL reset_evt_data: got %b, required 00000", evt_data); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL reset_held: got %b, required 0", held); end
        vectors++; if (multi !== 1'b0) begin miscompares++; $display("FAIL reset_multi: got %b, required 0", multi); end
        rst_n = 1'b1;
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            exp_cn = 4'b1111;
            exp_cn[(j / 8) % 4] = 1'b0;
            vectors++;
            if (col_n !== exp_cn) begin
                miscompares++;
                $display("FAIL scan_walk edge %0d: got %b, required %b", j, col_n, exp_cn);
            end
        end
    endtask

    task automatic test_single_key();
        align_scan();
        keys = 16'h0040;
        exp_q.push_back(5'b10110);
        repeat (96) @(posedge clk);
        @(negedge clk);
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_early: got %b, required 0", evt_valid); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid_latency: got %b, required 1", evt_valid); end
        vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL single_held: got %b, required 1", held); end
        wait_scans(2);
        keys = '0;
        exp_q.push_back(5'b00110);
        wait_scans(5);
        vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL single_release_held: got %b, required 0", held); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_missing: got %0d events pending, required 0", exp_q.size()); end
    endtask

    task automatic test_bounce();
        align_scan();
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (SCAN) @(negedge clk);
        end
        keys = '0;
        wait_scans(4);
        vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL bounce_held: got %b, required 0", held); end
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL bounce_valid: got %b, required 0", evt_valid); end
    endtask

    task automatic test_multi();
        keys = 16'h8001;
        wait_scans(5);
        vectors++; if (multi !== 1'b1) begin miscompares++; $display("FAIL multi_set: got %b, required 1", multi); end
        vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL multi_held: got %b, required 0", held); end
        keys = 16'h0001;
        exp_q.push_back(5'b10000);
        wait_scans(5);
        vectors++; if (multi !== 1'b0) begin miscompares++; $display("FAIL multi_clear: got %b, required 0", multi); end
        vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL multi_single_held: got %b, required 1", held); end
        keys = '0;
        exp_q.push_back(5'b00000);
        wait_scans(5);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL multi_missing: got %0d events pending, required 0", exp_q.size()); end
    endtask

    task automatic test_slide();
        keys = 16'h0020;
        exp_q.push_back(5'b10101);
        wait_scans(5);
        align_scan();
        keys = 16'h0200;
        exp_q.push_back(5'b00101);
        exp_q.push_back(5'b11001);
        wait_scans(5);
        vectors++; if (pop_cyc - prev_pop_cyc != 1) begin miscompares++; $display("FAIL slide_consecutive: got %0d cycles apart, required 1", pop_cyc - prev_pop_cyc); end
        vectors++; if (held !== 1'b1) begin miscompares++; $display("FAIL slide_held: got %b, required 1", held); end
        keys = '0;
        exp_q.push_back(5'b01001);
        wait_scans(5);
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL slide_missing: got %0d events pending, required 0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
            if (i < 4) exp_q.push_back((i % 2 == 0) ? 5'b10011 : 5'b00011);
            wait_scans(5);
            if (i == 3) begin
                vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b, required 0", overflow); end
                vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid: got %b, required 1", evt_valid); end
            end
        end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %b, required 1", overflow); end
        vectors++; if (evt_data !== exp_q[0]) begin miscompares++; $display("FAIL ovf_head: got %b, required %b", evt_data, exp_q[0]); end
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
        evt_ready = 1'b1;
        repeat (10) @(negedge clk);
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drained: got %b, required 0", evt_valid); end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL ovf_missing: got %0d events pending, required 0", exp_q.size()); end
        keys = '0;
        exp_q.push_back(5'b00011);
        wait_scans(5);
        vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL ovf_final_held: got %b, required 0", held); end
    endtask

    task automatic test_reset_mid();
        int n;
        evt_ready = 1'b0;
        keys = 16'h0008;
        exp_q.push_back(5'b10011);
        wait_scans(5);
        vectors++; if (evt_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_pending: got %b, required 1", evt_valid); end
        n = 0;
        while (col_n !== 4'b1011 && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (col_n !== 4'b1110) begin miscompares++; $display("FAIL rmid_col_n: got %b, required %b", col_n, 4'b1110); end
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_fifo: got %b, required 0", evt_valid); end
        vectors++; if (held !== 1'b0) begin miscompares++; $display("FAIL rmid_held: got %b, required 0", held); end
        exp_q.delete();
        keys = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        wait_scans(5);
        vectors++; if (evt_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_quiet: got %b, required 0", evt_valid); end
    endtask

    initial begin
        evt_ready    = 1'b1;
        overflow_clr = 1'b0;
        rst_n        = 1'b0;
        test_reset();
        test_single_key();
        test_bounce();
        test_multi();
        test_slide();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
